pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Supervises the 125 MHz-referenced PLL that generates the 40/160 MHz system clocks. Sequences the PLL reset, synchronises and debounces its `locked` flag, and holds the system reset until lock is stable. On loss of lock or lock timeout it re-issues the PLL reset, and it counts lock losses. Runs entirely on the free-running reference clock, upstream of the PLL `rst` input and downstream of its `locked` output.

Parameters:
RST_HOLD_CYCLES, 125, refclk cycles pll_rst is held high per reset pulse (1 us)
LOCK_STABLE_CYCLES, 12500, consecutive synchronised-lock cycles required before release (100 us)
LOCK_TIMEOUT_CYCLES, 125000, cycles allowed in WAIT_LOCK before a retry (1 ms)
MAX_RETRIES, 3, consecutive timeouts before entering FAULT; must be >= 1
SYNC_STAGES, 2, flops in the locked_in synchroniser; must be >= 2

Ports:
refclk  in  1  reference clock, 125 MHz, free-running
rst_n  in  1  asynchronous active-low reset
pll_locked_in  in  1  PLL locked flag, asynchronous to refclk
soft_relock  in  1  single-cycle request to restart the PLL sequence
pll_rst  out  1  active-high reset to the PLL
sys_rst_n  out  1  active-low system reset; high only while lock is qualified
clk_ok  out  1  high in RUN
fault  out  1  high in FAULT
lock_loss_cnt  out  8  saturating count of lock losses seen in RUN
state_dbg  out  3  current state encoding

Behaviour:
- Reset is one clock with asynchronous active-low rst_n. While rst_n=0 (async): pll_rst=1, sys_rst_n=0, clk_ok=0, fault=0, lock_loss_cnt=0, state_dbg=0 (PLL_RST), all counters 0, synchroniser cleared.
- locked_s is pll_locked_in delayed by SYNC_STAGES flops. All outputs are registered from the next state.
- One shared cycle counter, $clog2(max param)+1 bits wide; it clears on every state change. Separate retry counter.
- PLL_RST (0): pll_rst=1. Exits to WAIT_LOCK when counter = RST_HOLD_CYCLES-1.
- WAIT_LOCK (1): pll_rst=0.
  - locked_s=1 → DEBOUNCE.
  - counter = LOCK_TIMEOUT_CYCLES-1 → retry_cnt+1. If the new value = MAX_RETRIES → FAULT, otherwise → PLL_RST.
- DEBOUNCE (2):
  - locked_s=0 → WAIT_LOCK; the timeout restarts.
  - locked_s=1 and counter = LOCK_STABLE_CYCLES-1 → RUN.
- RUN (3): sys_rst_n=1, clk_ok=1, retry_cnt cleared on entry.
  - locked_s=0 → PLL_RST and lock_loss_cnt+1, saturating at 255.
- FAULT (4): fault=1, pll_rst=1, sys_rst_n=0. Leaves only on soft_relock → PLL_RST, with retry_cnt cleared.
- soft_relock:
  - In WAIT_LOCK, DEBOUNCE or RUN → PLL_RST, with no retry or loss increment.
  - In PLL_RST it restarts the hold count.
- Simultaneous loss of lock and soft_relock in RUN: treated as a loss, so it is counted.
- Release latency with lock already present at WAIT_LOCK entry: sys_rst_n rises LOCK_STABLE_CYCLES+1 cycles after WAIT_LOCK entry.
- Loss-of-lock latency: sys_rst_n falls SYNC_STAGES+1 cycles after pll_locked_in falls.
- Encodings 5-7 are illegal and recover to PLL_RST.

Optional Feature:
PLL_AUTO_RETRY_EN.
- Defined: timeout behaviour is as above (retry up to MAX_RETRIES).
- Undefined: the first WAIT_LOCK timeout goes directly to FAULT. The retry counter is omitted and MAX_RETRIES is ignored.

Decomposition:
- Package pll_sup_pkg holds:
  - the state enum: PLL_RST=0, WAIT_LOCK=1, DEBOUNCE=2, RUN=3, FAULT=4;
  - LOSS_CNT_W=8.
- One sub-module, bit_sync: an N-stage async-reset synchroniser used for pll_locked_in.

Test Plan (RST_HOLD=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2; cycle 0 = first edge after rst_n rises):
1. pll_locked_in tied 1, release rst_n → pll_rst high cycles 0-3 and low from cycle 4; sys_rst_n and clk_ok rise at cycle 13; state_dbg=3.
2. In DEBOUNCE, drop pll_locked_in for 3 cycles → returns to WAIT_LOCK; sys_rst_n stays 0; release occurs 8+1 cycles after locked_s returns.
3. In RUN, drop pll_locked_in → sys_rst_n=0 three cycles later; pll_rst pulses 4 cycles; lock_loss_cnt 0→1.
4. pll_locked_in held 0 with PLL_AUTO_RETRY_EN → two PLL_RST pulses separated by 32-cycle waits, then fault=1 and state_dbg=4. soft_relock → PLL_RST with fault=0. Without the macro → FAULT after the first timeout.
5. Force 260 loss events → lock_loss_cnt holds 255.
6. Assert rst_n mid-RUN → pll_rst=1, sys_rst_n=0, lock_loss_cnt=0 immediately, without waiting for a refclk edge.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor: the state encoding that is
// exported on state_dbg, the lock-loss counter width, and a small constant
// helper used to size the shared cycle counter.
// No ports (package).

package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        DEBOUNCE  = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_bit_sync.sv
// bit_sync
// N-stage flop chain that brings a single asynchronous level into the clk
// domain. All stages clear to 0 on reset, so a stale "locked" cannot leak
// through after reset.
// Ports:
//   clk    in  sampling clock
//   rst_n  in  asynchronous active-low reset
//   d      in  asynchronous input level
//   q      out synchronised level, d delayed by STAGES flops

module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences the PLL reset, qualifies the synchronised PLL lock flag and holds
// the system reset until lock has been stable for LOCK_STABLE_CYCLES. Loss of
// lock in RUN or a lock timeout restarts the PLL; lock losses are counted.
// Everything runs on the free-running reference clock.
//
// Build option: PLL_AUTO_RETRY_EN
//   defined   - a WAIT_LOCK timeout retries the PLL reset, entering FAULT only
//               after MAX_RETRIES consecutive timeouts
//   undefined - the first WAIT_LOCK timeout enters FAULT (no retry counter)
//
// Ports:
//   refclk         in   reference clock (125 MHz)
//   rst_n          in   asynchronous active-low reset
//   pll_locked_in  in   PLL locked flag, asynchronous to refclk
//   soft_relock    in   single-cycle request to restart the PLL sequence
//   pll_rst        out  active-high PLL reset
//   sys_rst_n      out  active-low system reset, high only in RUN
//   clk_ok         out  high in RUN
//   fault          out  high in FAULT
//   lock_loss_cnt  out  saturating count of lock losses seen in RUN
//   state_dbg      out  current state encoding
//
// state     | meaning
// ----------+---------------------------------------------------------------
// PLL_RST   | PLL reset asserted for RST_HOLD_CYCLES
// WAIT_LOCK | PLL reset released, waiting for synchronised lock (timed out)
// DEBOUNCE  | lock seen, must stay high LOCK_STABLE_CYCLES in a row
// RUN       | lock qualified, system reset released
// FAULT     | PLL never locked; held in reset until soft_relock

module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 125,
    parameter int LOCK_STABLE_CYCLES  = 12500,
    parameter int LOCK_TIMEOUT_CYCLES = 125000,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked_in,
    input  logic                  soft_relock,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  clk_ok,
    output logic                  fault,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]            state_dbg
);

    localparam int CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    pll_state_e       state;
    pll_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             locked_s;
    logic             loss_evt;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked_in),
        .q     (locked_s)
    );

`ifdef PLL_AUTO_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_inc;
    logic               retry_clr;
    logic               retry_last;

    assign retry_last = (retry_cnt == RETRY_W'(MAX_RETRIES - 1));
    // A successful lock or an operator restart out of FAULT starts a fresh
    // run of timeouts.
    assign retry_clr  = ((state_nxt == RUN) && (state != RUN)) ||
                        ((state == FAULT) && (state_nxt == PLL_RST));

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (retry_clr) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end
`else
    logic unused_max_retries;
    assign unused_max_retries = (MAX_RETRIES != 0);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        loss_evt  = 1'b0;
`ifdef PLL_AUTO_RETRY_EN
        retry_inc = 1'b0;
`endif
        case (state)
            PLL_RST: begin
                if (soft_relock) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (soft_relock) begin
                    state_nxt = PLL_RST;
                end else if (locked_s) begin
                    state_nxt = DEBOUNCE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
`ifdef PLL_AUTO_RETRY_EN
                    retry_inc = 1'b1;
                    state_nxt = retry_last ? FAULT : PLL_RST;
`else
                    state_nxt = FAULT;
`endif
                end
            end
            DEBOUNCE: begin
                if (soft_relock) begin
                    state_nxt = PLL_RST;
                end else if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                // Loss takes priority so a coincident soft_relock is still counted.
                if (!locked_s) begin
                    state_nxt = PLL_RST;
                    loss_evt  = 1'b1;
                end else if (soft_relock) begin
                    state_nxt = PLL_RST;
                end
            end
            FAULT: begin
                cnt_nxt = '0;
                if (soft_relock) begin
                    state_nxt = PLL_RST;
                end
            end
            default: begin
                state_nxt = PLL_RST;
            end
        endcase

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            clk_ok        <= 1'b0;
            fault         <= 1'b0;
            lock_loss_cnt <= '0;
            state_dbg     <= 3'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pll_rst   <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
            sys_rst_n <= (state_nxt == RUN);
            clk_ok    <= (state_nxt == RUN);
            fault     <= (state_nxt == FAULT);
            state_dbg <= state_nxt;
            if (loss_evt && (lock_loss_cnt != '1)) begin
                lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
// Directed scenarios plus randomized lock/relock traffic for
// pll_lock_supervisor, checked against a phase/elapsed-time reference model.
// Honours PLL_AUTO_RETRY_EN the same way as the design.

module tb_pll_lock_supervisor;

    localparam int RST_HOLD    = 4;
    localparam int STABLE      = 8;
    localparam int TIMEOUT     = 32;
    localparam int MAX_RETRIES = 2;
    localparam int SYNC        = 2;
`ifdef PLL_AUTO_RETRY_EN
    localparam int TIMEOUTS_TO_FAULT = MAX_RETRIES;
`else
    localparam int TIMEOUTS_TO_FAULT = 1;
`endif

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked_in = 1'b0;
    logic       soft_relock = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       clk_ok;
    logic       fault;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES     (RST_HOLD),
        .LOCK_STABLE_CYCLES  (STABLE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES         (MAX_RETRIES),
        .SYNC_STAGES         (SYNC)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked_in (pll_locked_in),
        .soft_relock   (soft_relock),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .clk_ok        (clk_ok),
        .fault         (fault),
        .lock_loss_cnt (lock_loss_cnt),
        .state_dbg     (state_dbg)
    );

    always #4 refclk = ~refclk;

    // ---------------- reference model ----------------
    typedef enum int {M_RST = 0, M_WAIT = 1, M_DEB = 2, M_RUN = 3, M_FAULT = 4} mphase_t;

    mphase_t ph;
    int      in_phase;   // edges already spent in the current phase
    int      retries;
    int      losses;
    bit      lsync[$];   // pipeline of raw lock samples; front = synchronised value

    task automatic model_reset();
        ph       = M_RST;
        in_phase = 0;
        retries  = 0;
        losses   = 0;
        lsync    = {};
        for (int i = 0; i < SYNC; i++) lsync.push_back(1'b0);
    endtask

    task automatic model_edge(input bit pin, input bit sr);
        bit      ls;
        bit      lost;
        mphase_t nx;
        ls = lsync[0];
        void'(lsync.pop_front());
        lsync.push_back(pin);
        nx   = ph;
        lost = 1'b0;
        case (ph)
            M_RST:   if (!sr && (in_phase + 1 == RST_HOLD)) nx = M_WAIT;
            M_WAIT: begin
                if (sr) nx = M_RST;
                else if (ls) nx = M_DEB;
                else if (in_phase + 1 == TIMEOUT) begin
                    retries = retries + 1;
                    nx = (retries >= TIMEOUTS_TO_FAULT) ? M_FAULT : M_RST;
                end
            end
            M_DEB: begin
                if (sr) nx = M_RST;
                else if (!ls) nx = M_WAIT;
                else if (in_phase + 1 == STABLE) nx = M_RUN;
            end
            M_RUN: begin
                if (!ls) begin nx = M_RST; lost = 1'b1; end
                else if (sr) nx = M_RST;
            end
            M_FAULT: if (sr) begin nx = M_RST; retries = 0; end
            default: nx = M_RST;
        endcase
        if (nx == M_RUN) retries = 0;
        if (lost && losses < 255) losses = losses + 1;
        if (nx != ph || (ph == M_RST && sr)) in_phase = 0;
        else in_phase = in_phase + 1;
        ph = nx;
    endtask

    function automatic logic [14:0] exp_vec();
        return {(ph == M_RST || ph == M_FAULT), (ph == M_RUN), (ph == M_RUN),
                (ph == M_FAULT), 8'(losses), 3'(ph)};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {pll_rst, sys_rst_n, clk_ok, fault, lock_loss_cnt, state_dbg};
    endfunction

    task automatic step();
        @(posedge refclk);
        model_edge(pll_locked_in, soft_relock);
        #1;
    endtask

    task automatic wait_phase(input mphase_t target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (ph == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        pll_locked_in = 1'b1;
        #20;
        n_checks++;
        if ({pll_rst, sys_rst_n, clk_ok, fault, lock_loss_cnt, state_dbg} !== 15'b1000_00000000_000) begin
            n_fail++;
            $display("FAIL reset_values got=%b exp=%b", dut_vec(), 15'b1000_00000000_000);
        end
    endtask

    task automatic test_release();
        @(negedge refclk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 16; k++) begin
            step();
            n_checks++;
            if (pll_rst !== (k < RST_HOLD - 1)) begin
                n_fail++;
                $display("FAIL release_pll_rst edge=%0d got=%b exp=%b", k, pll_rst, (k < RST_HOLD - 1));
            end
            n_checks++;
            if ({sys_rst_n, clk_ok} !== {2{k >= RST_HOLD + STABLE}}) begin
                n_fail++;
                $display("FAIL release_sys_rst edge=%0d got=%b%b exp=%b", k, sys_rst_n, clk_ok, (k >= RST_HOLD + STABLE));
            end
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL release_model edge=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (state_dbg !== 3'd3) begin
            n_fail++;
            $display("FAIL release_state got=%0d exp=3", state_dbg);
        end
    endtask

    task automatic test_debounce_glitch();
        bit ok;
        soft_relock = 1'b1;
        step();
        soft_relock = 1'b0;
        n_checks++;
        if (state_dbg !== 3'd0 || lock_loss_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch_soft_relock got state=%0d loss=%0d exp state=0 loss=0", state_dbg, lock_loss_cnt);
        end
        wait_phase(M_DEB, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL glitch_reach_debounce got=timeout exp=DEBOUNCE");
        end
        pll_locked_in = 1'b0;
        repeat (3) step();
        pll_locked_in = 1'b1;
        n_checks++;
        if (state_dbg !== 3'd1 || sys_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_back_to_wait got state=%0d sys_rst_n=%b exp state=1 sys_rst_n=0", state_dbg, sys_rst_n);
        end
        // restored level is sampled on the next edge; synchroniser adds SYNC-1
        // more, then one edge into DEBOUNCE and STABLE edges to RUN
        for (int j = 1; j <= SYNC + STABLE + 1; j++) begin
            step();
            n_checks++;
            if (sys_rst_n !== (j == SYNC + STABLE + 1)) begin
                n_fail++;
                $display("FAIL glitch_release step=%0d got=%b exp=%b", j, sys_rst_n, (j == SYNC + STABLE + 1));
            end
        end
    endtask

    task automatic test_loss();
        int high_cycles;
        bit ok;
        high_cycles = 0;
        pll_locked_in = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 3) pll_locked_in = 1'b1;
            if (pll_rst) high_cycles++;
            n_checks++;
            if (sys_rst_n !== (j < SYNC + 1)) begin
                n_fail++;
                $display("FAIL loss_sys_rst step=%0d got=%b exp=%b", j, sys_rst_n, (j < SYNC + 1));
            end
            n_checks++;
            if (lock_loss_cnt !== ((j >= SYNC + 1) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL loss_count step=%0d got=%0d exp=%0d", j, lock_loss_cnt, (j >= SYNC + 1) ? 1 : 0);
            end
        end
        n_checks++;
        if (high_cycles != RST_HOLD) begin
            n_fail++;
            $display("FAIL loss_pll_rst_width got=%0d exp=%0d", high_cycles, RST_HOLD);
        end
        wait_phase(M_RUN, 40, ok);
        n_checks++;
        if (!ok || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL loss_relock got=%b exp=%b ok=%0d", dut_vec(), exp_vec(), ok);
        end
    endtask

    task automatic test_loss_with_soft();
        bit ok;
        pll_locked_in = 1'b0;
        step();
        step();
        soft_relock = 1'b1;
        step();
        soft_relock = 1'b0;
        n_checks++;
        if (lock_loss_cnt !== 8'd2 || state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL loss_soft_counted got loss=%0d state=%0d exp loss=2 state=0", lock_loss_cnt, state_dbg);
        end
        pll_locked_in = 1'b1;
        wait_phase(M_RUN, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL loss_soft_relock got=timeout exp=RUN");
        end
    endtask

    task automatic test_timeout();
        int  span;
        int  rises;
        logic prev;
        span  = (RST_HOLD + TIMEOUT) * TIMEOUTS_TO_FAULT;
        rises = 0;
        prev  = pll_rst;
        pll_locked_in = 1'b0;
        soft_relock   = 1'b1;
        step();
        soft_relock   = 1'b0;
        if (pll_rst && !prev) rises++;
        prev = pll_rst;
        for (int j = 1; j <= span; j++) begin
            step();
            if (j < span && pll_rst && !prev) rises++;
            prev = pll_rst;
            n_checks++;
            if (fault !== (j >= span)) begin
                n_fail++;
                $display("FAIL timeout_fault step=%0d got=%b exp=%b", j, fault, (j >= span));
            end
        end
        n_checks++;
        if (rises != TIMEOUTS_TO_FAULT) begin
            n_fail++;
            $display("FAIL timeout_pulses got=%0d exp=%0d", rises, TIMEOUTS_TO_FAULT);
        end
        n_checks++;
        if (state_dbg !== 3'd4 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || lock_loss_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL timeout_fault_state got=%b exp state=4 pll_rst=1 sys_rst_n=0 loss=2", dut_vec());
        end
        repeat (5) step();
        n_checks++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_sticky got=%b exp=1", fault);
        end
        soft_relock = 1'b1;
        step();
        soft_relock = 1'b0;
        n_checks++;
        if (fault !== 1'b0 || state_dbg !== 3'd0 || pll_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_exit got fault=%b state=%0d pll_rst=%b exp 0/0/1", fault, state_dbg, pll_rst);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                pll_locked_in = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 40);
            end
            hold--;
            soft_relock = ($urandom_range(0, 39) == 0);
            step();
            soft_relock = 1'b0;
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        for (int e = 0; e < 260; e++) begin
            pll_locked_in = 1'b1;
            wait_phase(M_RUN, 100, ok);
            pll_locked_in = 1'b0;
            if (ok) wait_phase(M_RST, 10, ok);
            n_checks++;
            if (!ok || lock_loss_cnt !== 8'(losses)) begin
                n_fail++;
                $display("FAIL saturation event=%0d got=%0d exp=%0d ok=%0d", e, lock_loss_cnt, losses, ok);
            end
        end
        n_checks++;
        if (lock_loss_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation_final got=%0d exp=255", lock_loss_cnt);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        pll_locked_in = 1'b1;
        wait_phase(M_RUN, 60, ok);
        n_checks++;
        if (!ok || sys_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre_run got sys_rst_n=%b ok=%0d exp=1", sys_rst_n, ok);
        end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pll_rst, sys_rst_n, clk_ok, fault, lock_loss_cnt, state_dbg} !== 15'b1000_00000000_000) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=%b", dut_vec(), 15'b1000_00000000_000);
        end
        model_reset();
        #10;
        @(negedge refclk);
        rst_n = 1'b1;
        wait_phase(M_RUN, 60, ok);
        n_checks++;
        if (!ok || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_recover got=%b exp=%b ok=%0d", dut_vec(), exp_vec(), ok);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_release();
        test_debounce_glitch();
        test_loss();
        test_loss_with_soft();
        test_timeout();
        test_random();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
